// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
// Holds the clear-sequencer state encoding and the address-range check.
package regfile_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int unsigned N_RD_PORTS = 2;

  // True when addr names a physically present register (DEPTH need not be a power of two)
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks every register address once after a clear request.
// Owns the state, the address counter and the registered busy flag.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  clr_state_e    state_r;
  clr_state_e    state_s;
  logic [AW-1:0] cnt_r;
  logic [AW-1:0] cnt_s;
  logic          busy_r;

  // Next-state and counter logic; clr_req is only looked at while idle
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (clr_req) begin
          state_s = CLEAR;
        end else begin
          state_s = IDLE;
        end
        cnt_s = '0;
      end
      CLEAR: begin
        if (cnt_r == AW'(DEPTH - 1)) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else begin
          state_s = CLEAR;
          cnt_s   = cnt_r + AW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, counter and busy registers; busy mirrors the next state so it carries no path from clr_req
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s == CLEAR);
    end
  end

  assign busy     = busy_r;
  assign clr_we   = (state_r == CLEAR);
  assign clr_addr = cnt_r;

endmodule

// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with same-cycle write bypass,
// optional hardwired-zero register 0 and a sequenced run-time clear.
module regfile_param
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rd_addr0,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data0,
  output logic [WIDTH-1:0] rd_data1,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  input  logic             clr_req,
  output logic             busy
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             busy_s;
  logic             clr_we_s;
  logic [AW-1:0]    clr_addr_s;
  logic             wr_ok_s;
  logic [AW-1:0]    rd_addr_s [N_RD_PORTS];
  logic [WIDTH-1:0] rd_data_s [N_RD_PORTS];

  regfile_clr_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy_s),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s)
  );

  // A user write commits only when idle, in range, and not aimed at a hardwired zero
  always_comb begin
    wr_ok_s = 1'b0;
    if (wr_en && !clr_we_s && addr_in_range(32'(wr_addr), DEPTH)
        && !((ZERO_REG != 0) && (wr_addr == AW'(0)))) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Storage array; the clear port wins over the user port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (clr_we_s) begin
      mem_r[clr_addr_s] <= '0;
    end else if (wr_ok_s) begin
      mem_r[wr_addr] <= wr_data;
    end else begin
      mem_r <= mem_r;
    end
  end

  assign rd_addr_s[0] = rd_addr0;
  assign rd_addr_s[1] = rd_addr1;

  // Identical read/bypass mux per port, in priority order
  always_comb begin
    for (int p = 0; p < N_RD_PORTS; p++) begin
      rd_data_s[p] = '0;
      if (busy_s) begin
        rd_data_s[p] = '0;
      end else if ((ZERO_REG != 0) && (rd_addr_s[p] == AW'(0))) begin
        rd_data_s[p] = '0;
      end else if (!addr_in_range(32'(rd_addr_s[p]), DEPTH)) begin
        rd_data_s[p] = '0;
      end else if (wr_ok_s && (wr_addr == rd_addr_s[p])) begin
        rd_data_s[p] = wr_data;
      end else begin
        rd_data_s[p] = mem_r[rd_addr_s[p]];
      end
    end
  end

  assign rd_data0 = rd_data_s[0];
  assign rd_data1 = rd_data_s[1];
  assign busy     = busy_s;

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param: a default 32x32 instance
// and a 16-bit x 8-entry instance sharing clock and reset.
module tb_regfile_param;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]  rd_addr0, rd_addr1, wr_addr;
  logic [31:0] rd_data0, rd_data1, wr_data;
  logic        wr_en, clr_req, busy;

  logic [2:0]  s_rd_addr0, s_rd_addr1, s_wr_addr;
  logic [15:0] s_rd_data0, s_rd_data1, s_wr_data;
  logic        s_wr_en, s_clr_req, s_busy;

  int checks = 0;
  int errors = 0;

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .clr_req(clr_req), .busy(busy)
  );

  regfile_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr0(s_rd_addr0), .rd_addr1(s_rd_addr1),
    .rd_data0(s_rd_data0), .rd_data1(s_rd_data1),
    .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_en(s_wr_en),
    .clr_req(s_clr_req), .busy(s_busy)
  );

  task automatic wr32(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_addr = a; wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Pulse clr_req on the 32-bit instance and count negedges with busy high
  task automatic run_clear(output int n);
    n = 0;
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rd_addr0 = 5'd0; rd_addr1 = 5'd3; wr_addr = 5'd0; wr_data = 32'd0;
    wr_en = 1'b0; clr_req = 1'b0;
    s_rd_addr0 = 3'd0; s_rd_addr1 = 3'd0; s_wr_addr = 3'd0; s_wr_data = 16'd0;
    s_wr_en = 1'b0; s_clr_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy16: got %b expected 0", s_busy); end
    checks++; if (rd_data1 !== 32'd0) begin errors++; $display("FAIL reset_rd3: got %h expected 0", rd_data1); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    wr32(5'd8, 32'h0000_0007);
    rd_addr0 = 5'd8; rd_addr1 = 5'd3;
    #1;
    checks++; if (rd_data0 !== 32'h0000_0007) begin errors++; $display("FAIL wr_rd8: got %h expected 00000007", rd_data0); end
    checks++; if (rd_data1 !== 32'd0) begin errors++; $display("FAIL rd3: got %h expected 00000000", rd_data1); end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; wr_en = 1'b1;
    rd_addr0 = 5'd5; rd_addr1 = 5'd5;
    #1;
    checks++; if (rd_data0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_p0: got %h expected deadbeef", rd_data0); end
    checks++; if (rd_data1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_p1: got %h expected deadbeef", rd_data1); end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    checks++; if (rd_data0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_stored: got %h expected deadbeef", rd_data0); end
  endtask

  task automatic test_zero_reg;
    @(negedge clk);
    wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; wr_en = 1'b1;
    rd_addr0 = 5'd0; rd_addr1 = 5'd0;
    #1;
    checks++; if (rd_data0 !== 32'd0) begin errors++; $display("FAIL zero_during_p0: got %h expected 0", rd_data0); end
    checks++; if (rd_data1 !== 32'd0) begin errors++; $display("FAIL zero_during_p1: got %h expected 0", rd_data1); end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    checks++; if (rd_data0 !== 32'd0) begin errors++; $display("FAIL zero_after: got %h expected 0", rd_data0); end
  endtask

  task automatic test_clear;
    int n;
    for (int i = 1; i < 32; i++) wr32(5'(i), 32'(i));
    rd_addr0 = 5'd31; rd_addr1 = 5'd17;
    #1;
    checks++; if (rd_data0 !== 32'd31) begin errors++; $display("FAIL fill31: got %h expected 0000001f", rd_data0); end
    checks++; if (rd_data1 !== 32'd17) begin errors++; $display("FAIL fill17: got %h expected 00000011", rd_data1); end
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      rd_addr0 = 5'(n); rd_addr1 = 5'd31;
      if (n == 10) begin
        wr_addr = 5'd4; wr_data = 32'h0000_0BAD; wr_en = 1'b1; rd_addr0 = 5'd4;
      end else begin
        wr_en = 1'b0;
      end
      #1;
      checks++;
      if (rd_data0 !== 32'd0 || rd_data1 !== 32'd0) begin
        errors++; $display("FAIL clear_read cycle %0d: got %h/%h expected 0/0", n, rd_data0, rd_data1);
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    checks++; if (n !== 32) begin errors++; $display("FAIL clear_busy_len: got %0d expected 32", n); end
    for (int a = 0; a < 32; a++) begin
      rd_addr0 = 5'(a); rd_addr1 = 5'(31 - a);
      #1;
      checks++;
      if (rd_data0 !== 32'd0 || rd_data1 !== 32'd0) begin
        errors++; $display("FAIL cleared reg %0d: got %h/%h expected 0/0", a, rd_data0, rd_data1);
      end
    end
    wr32(5'd4, 32'h0000_0044);
    rd_addr0 = 5'd4;
    #1;
    checks++; if (rd_data0 !== 32'h0000_0044) begin errors++; $display("FAIL post_clear_write: got %h expected 00000044", rd_data0); end
  endtask

  task automatic test_reset_mid_clear;
    int n;
    wr32(5'd20, 32'h0000_1234);
    wr32(5'd2, 32'h0000_0022);
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_clear_busy: got %b expected 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_abort_busy: got %b expected 0", busy); end
    for (int a = 0; a < 32; a++) begin
      rd_addr0 = 5'(a); rd_addr1 = 5'd20;
      #1;
      checks++;
      if (rd_data0 !== 32'd0 || rd_data1 !== 32'd0) begin
        errors++; $display("FAIL abort_reg %0d: got %h/%h expected 0/0", a, rd_data0, rd_data1);
      end
    end
    run_clear(n);
    checks++; if (n !== 32) begin errors++; $display("FAIL reclear_busy_len: got %0d expected 32", n); end
  endtask

  task automatic test_param;
    int n;
    @(negedge clk);
    s_wr_addr = 3'd7; s_wr_data = 16'hA5A5; s_wr_en = 1'b1;
    @(negedge clk);
    s_wr_en = 1'b0; s_rd_addr0 = 3'd7; s_rd_addr1 = 3'd7;
    #1;
    checks++; if (s_rd_data0 !== 16'hA5A5) begin errors++; $display("FAIL p16_rd7_p0: got %h expected a5a5", s_rd_data0); end
    checks++; if (s_rd_data1 !== 16'hA5A5) begin errors++; $display("FAIL p16_rd7_p1: got %h expected a5a5", s_rd_data1); end
    @(negedge clk); s_clr_req = 1'b1;
    @(negedge clk); s_clr_req = 1'b0;
    n = 0;
    while (s_busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL p16_busy_len: got %0d expected 8", n); end
    #1;
    checks++; if (s_rd_data0 !== 16'd0) begin errors++; $display("FAIL p16_cleared7: got %h expected 0000", s_rd_data0); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_clear();
    test_reset_mid_clear();
    test_param();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
